// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle controller
package riscv_ctrl_pkg;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // func7 value that selects SUB / SRA
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    TC_NONE         = 2'd0,
    TC_ILLEGAL      = 2'd1,
    TC_DMEM_TIMEOUT = 2'd2
  } trap_cause_e;

  // func3 -> ALU operation; alt (func7[5]) turns ADD into SUB and SRL into SRA
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - opcode/func3/func7 to ALU select, operand select and legality
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output logic [3:0] alu_op_o,
  output logic       alu_src_b_o,
  output logic       illegal_o
);

  logic f7_known;
  logic alt_ok;
  logic is_shift;

  // func7 must be base or alt, and alt is only meaningful for ADD/SUB and SRL/SRA
  assign f7_known = (func7_i == F7_BASE) || (func7_i == F7_ALT);
  assign alt_ok   = (func7_i != F7_ALT) || (func3_i == 3'b000) || (func3_i == 3'b101);
  assign is_shift = (func3_i == 3'b001) || (func3_i == 3'b101);

  // Per-opcode ALU select, immediate select and illegal-encoding detection
  always_comb begin
    alu_op_o    = ALU_ADD;
    alu_src_b_o = 1'b1;
    illegal_o   = 1'b0;
    case (opcode_i)
      OP_R: begin
        alu_src_b_o = 1'b0;
        alu_op_o    = alu_map(func3_i, func7_i[5]);
        illegal_o   = !(f7_known && alt_ok);
      end
      OP_IALU: begin
        // ADDI has no SUBI form: func7 bits there are part of the immediate
        alu_op_o  = (func3_i == 3'b000) ? ALU_ADD : alu_map(func3_i, func7_i[5]);
        illegal_o = is_shift && !(f7_known && alt_ok);
      end
      OP_LOAD: begin
        illegal_o = (func3_i == 3'b011) || (func3_i == 3'b110) || (func3_i == 3'b111);
      end
      OP_STORE: begin
        illegal_o = (func3_i > 3'b010);
      end
      OP_BRANCH: begin
        alu_src_b_o = 1'b0;
        alu_op_o    = ALU_SUB;
        illegal_o   = (func3_i == 3'b010) || (func3_i == 3'b011);
      end
      OP_JAL: begin
        alu_op_o = ALU_ADD;
      end
      OP_LUI: begin
        alu_op_o = ALU_PASS_B;
      end
      default: begin
        alu_src_b_o = 1'b0;
        illegal_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rd,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_src,
  output logic [3:0]  alu_op,
  output logic        alu_src_b,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam int              WaitW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              alu_src_b_q, alu_src_b_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [1:0]        trap_cause_q, trap_cause_d;
  logic [31:0]       instret_q, instret_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic [3:0]        dec_alu_op;
  logic              dec_alu_src_b;
  logic              dec_illegal;
  logic [1:0]        dec_wb_sel;
  logic              is_branch, is_load, is_store;

  logic              imem_req_c, ir_load_c;

  alu_op_decoder u_alu_op_decoder (
    .opcode_i    (opcode),
    .func3_i     (func3),
    .func7_i     (func7),
    .alu_op_o    (dec_alu_op),
    .alu_src_b_o (dec_alu_src_b),
    .illegal_o   (dec_illegal)
  );

  assign is_branch  = (opcode == OP_BRANCH);
  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign dec_wb_sel = is_load ? WB_MEM : ((opcode == OP_JAL) ? WB_PC4 : WB_ALU);

  // Next-state, held datapath selects and per-state control outputs
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_src_b_d  = alu_src_b_q;
    wb_sel_d     = wb_sel_q;
    trap_cause_d = trap_cause_q;
    wait_d       = wait_q;
    instret_d    = instret_q;

    imem_req_c = 1'b0;
    ir_load_c  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = alu_op_q;
    alu_src_b  = alu_src_b_q;
    wb_sel     = wb_sel_q;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d      = S_TRAP;
          trap_cause_d = TC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Drive the decoded selects now and capture them so MEM/WB see the same values
        alu_op      = dec_alu_op;
        alu_src_b   = dec_alu_src_b;
        wb_sel      = dec_wb_sel;
        alu_op_d    = dec_alu_op;
        alu_src_b_d = dec_alu_src_b;
        wb_sel_d    = dec_wb_sel;
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          wait_d = '0;
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WaitLast) begin
          // Ready is still honoured in the last allowed cycle; only its absence traps
          wait_d       = '0;
          state_d      = S_TRAP;
          trap_cause_d = TC_DMEM_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = (rd != 5'd0);
        pc_write  = 1'b1;
        pc_src    = (wb_sel_q == WB_PC4);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (pc_write) begin
      instret_d = instret_q + 32'd1;
    end
  end

  // FETCH is the reset state, so the fetch request is held off while reset is asserted
  assign imem_req   = imem_req_c & rst_n;
  assign ir_load    = ir_load_c & rst_n;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = trap_cause_q;
  assign instret    = instret_q;

  // Controller state register; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      alu_op_q     <= ALU_ADD;
      alu_src_b_q  <= 1'b0;
      wb_sel_q     <= WB_ALU;
      trap_cause_q <= TC_NONE;
      wait_q       <= '0;
      instret_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_src_b_q  <= alu_src_b_d;
      wb_sel_q     <= wb_sel_d;
      trap_cause_q <= trap_cause_d;
      wait_q       <= wait_d;
      instret_q    <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // {imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we, reg_write}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_FETCH = 7'b1100000;
  localparam logic [6:0] C_FWAIT = 7'b1000000;
  localparam logic [6:0] C_MEMR  = 7'b0000100;
  localparam logic [6:0] C_MEMW  = 7'b0000110;
  localparam logic [6:0] C_WB    = 7'b0010001;
  localparam logic [6:0] C_PCT   = 7'b0011000;
  localparam logic [6:0] C_BRN   = 7'b0010000;
  localparam logic [3:0] NA      = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_load, pc_write, pc_src;
  logic [3:0]  alu_op;
  logic        alu_src_b, dmem_req, dmem_we, reg_write;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .rd           (rd),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_op       (alu_op),
    .alu_src_b    (alu_src_b),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] r);
    opcode = op;
    func3  = f3;
    func7  = f7;
    rd     = r;
  endtask

  // One controller cycle: settle, compare, then advance to the next falling edge
  task automatic cyc(input string tag, input logic [6:0] ctl, input logic [3:0] op,
                     input logic sb, input logic [1:0] wb, input logic [1:0] cause);
    #1;
    chk({tag, ".ctl"}, {25'd0, imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we, reg_write},
        {25'd0, ctl});
    if (op != NA) begin
      chk({tag, ".alu_op"}, {28'd0, alu_op}, {28'd0, op});
      chk({tag, ".alu_src_b"}, {31'd0, alu_src_b}, {31'd0, sb});
      chk({tag, ".wb_sel"}, {30'd0, wb_sel}, {30'd0, wb});
    end
    chk({tag, ".trap"}, {31'd0, trap}, {31'd0, (cause != 2'd0)});
    chk({tag, ".cause"}, {30'd0, trap_cause}, {30'd0, cause});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset away from the rising edge, check the idle state, then release
  task automatic reset_chk(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, ".ctl"}, {25'd0, imem_req, ir_load, pc_write, pc_src, dmem_req, dmem_we, reg_write},
        32'd0);
    chk({tag, ".alu_op"}, {28'd0, alu_op}, 32'd0);
    chk({tag, ".sel"}, {30'd0, alu_src_b, wb_sel[0]}, 32'd0);
    chk({tag, ".wb_sel"}, {30'd0, wb_sel}, 32'd0);
    chk({tag, ".trap"}, {29'd0, trap, trap_cause}, 32'd0);
    chk({tag, ".instret"}, instret, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    set_ins(7'd0, 3'd0, 7'd0, 5'd0);
    @(negedge clk);
    reset_chk("reset0");

    // R-type ADD then SUB
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    set_ins(OP_R, 3'b000, 7'h00, 5'd3);
    cyc("add.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("add.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("add.e", C_IDLE, 4'd0, 1'b0, 2'd0, 2'd0);
    cyc("add.w", C_WB, 4'd0, 1'b0, 2'd0, 2'd0);
    set_ins(OP_R, 3'b000, 7'h20, 5'd4);
    cyc("sub.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("sub.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("sub.e", C_IDLE, 4'd1, 1'b0, 2'd0, 2'd0);
    cyc("sub.w", C_WB, 4'd1, 1'b0, 2'd0, 2'd0);
    chk("instret.r", instret, 32'd2);

    // LOAD with ready arriving in the fourth (last allowed) MEM cycle
    set_ins(OP_LOAD, 3'b010, 7'h00, 5'd7);
    cyc("lw.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("lw.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("lw.e", C_IDLE, 4'd0, 1'b1, 2'd1, 2'd0);
    dmem_ready = 1'b0;
    cyc("lw.m1", C_MEMR, 4'd0, 1'b1, 2'd1, 2'd0);
    cyc("lw.m2", C_MEMR, 4'd0, 1'b1, 2'd1, 2'd0);
    cyc("lw.m3", C_MEMR, 4'd0, 1'b1, 2'd1, 2'd0);
    dmem_ready = 1'b1;
    cyc("lw.m4", C_MEMR, 4'd0, 1'b1, 2'd1, 2'd0);
    cyc("lw.w", C_WB, 4'd0, 1'b1, 2'd1, 2'd0);
    chk("instret.lw", instret, 32'd3);

    // BRANCH taken then not taken, rd field nonzero but never written
    set_ins(OP_BRANCH, 3'b000, 7'h00, 5'd9);
    branch_taken = 1'b1;
    cyc("bt.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("bt.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("bt.e", C_PCT, 4'd1, 1'b0, 2'd0, 2'd0);
    branch_taken = 1'b0;
    cyc("bn.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("bn.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("bn.e", C_BRN, 4'd1, 1'b0, 2'd0, 2'd0);
    chk("instret.br", instret, 32'd5);

    // JAL rd=0, ANDI, LUI, SRAI
    set_ins(OP_JAL, 3'b000, 7'h00, 5'd0);
    cyc("jal.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("jal.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("jal.e", C_IDLE, 4'd0, 1'b1, 2'd2, 2'd0);
    cyc("jal.w", C_PCT, 4'd0, 1'b1, 2'd2, 2'd0);
    set_ins(OP_IALU, 3'b111, 7'h00, 5'd5);
    cyc("andi.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("andi.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("andi.e", C_IDLE, 4'd9, 1'b1, 2'd0, 2'd0);
    cyc("andi.w", C_WB, 4'd9, 1'b1, 2'd0, 2'd0);
    set_ins(OP_LUI, 3'b000, 7'h00, 5'd1);
    cyc("lui.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("lui.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("lui.e", C_IDLE, 4'd10, 1'b1, 2'd0, 2'd0);
    cyc("lui.w", C_WB, 4'd10, 1'b1, 2'd0, 2'd0);
    set_ins(OP_IALU, 3'b101, 7'h20, 5'd2);
    cyc("srai.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("srai.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("srai.e", C_IDLE, 4'd7, 1'b1, 2'd0, 2'd0);
    cyc("srai.w", C_WB, 4'd7, 1'b1, 2'd0, 2'd0);
    chk("instret.alu", instret, 32'd9);

    // Unknown opcode traps and stays idle with instret frozen
    set_ins(7'b1111111, 3'b000, 7'h00, 5'd1);
    cyc("ill.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("ill.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("ill.t1", C_IDLE, NA, 1'b0, 2'd0, 2'd1);
    cyc("ill.t2", C_IDLE, NA, 1'b0, 2'd0, 2'd1);
    cyc("ill.t3", C_IDLE, NA, 1'b0, 2'd0, 2'd1);
    chk("instret.ill", instret, 32'd9);
    reset_chk("reset.ill");

    // R-type alt func7 with func3=001 is illegal
    set_ins(OP_R, 3'b001, 7'h20, 5'd1);
    cyc("rill.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("rill.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("rill.t1", C_IDLE, NA, 1'b0, 2'd0, 2'd1);
    cyc("rill.t2", C_IDLE, NA, 1'b0, 2'd0, 2'd1);
    reset_chk("reset.rill");

    // STORE with dmem_ready never high: four MEM cycles, then timeout trap
    set_ins(OP_STORE, 3'b010, 7'h00, 5'd0);
    dmem_ready = 1'b0;
    cyc("sw.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("sw.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("sw.e", C_IDLE, 4'd0, 1'b1, 2'd0, 2'd0);
    cyc("sw.m1", C_MEMW, 4'd0, 1'b1, 2'd0, 2'd0);
    cyc("sw.m2", C_MEMW, 4'd0, 1'b1, 2'd0, 2'd0);
    cyc("sw.m3", C_MEMW, 4'd0, 1'b1, 2'd0, 2'd0);
    cyc("sw.m4", C_MEMW, 4'd0, 1'b1, 2'd0, 2'd0);
    dmem_ready = 1'b1;
    cyc("sw.t1", C_IDLE, NA, 1'b0, 2'd0, 2'd2);
    cyc("sw.t2", C_IDLE, NA, 1'b0, 2'd0, 2'd2);
    chk("instret.sw", instret, 32'd0);
    reset_chk("reset.sw");

    // Retire one ADD, then reset while stalled in FETCH
    set_ins(OP_R, 3'b000, 7'h00, 5'd3);
    cyc("add2.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("add2.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("add2.e", C_IDLE, 4'd0, 1'b0, 2'd0, 2'd0);
    cyc("add2.w", C_WB, 4'd0, 1'b0, 2'd0, 2'd0);
    chk("instret.add2", instret, 32'd1);
    imem_ready = 1'b0;
    cyc("fw1", C_FWAIT, NA, 1'b0, 2'd0, 2'd0);
    cyc("fw2", C_FWAIT, NA, 1'b0, 2'd0, 2'd0);
    reset_chk("reset.mid");
    imem_ready = 1'b1;
    cyc("res.f", C_FETCH, NA, 1'b0, 2'd0, 2'd0);
    cyc("res.d", C_IDLE, NA, 1'b0, 2'd0, 2'd0);
    cyc("res.e", C_IDLE, 4'd0, 1'b0, 2'd0, 2'd0);
    cyc("res.w", C_WB, 4'd0, 1'b0, 2'd0, 2'd0);
    chk("instret.res", instret, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32I core. Consumes the opcode, func3, func7 and rd fields produced by the instruction decoder from the instruction register. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives IR load, PC update, ALU operation select, register-file write, data-memory request and writeback mux select, and traps on illegal encodings or data-memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for dmem_ready in MEM before trapping (≥1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  instruction opcode field (decoder output).
- func3  in  3  func3 field.
- func7  in  7  func7 field.
- rd  in  5  destination register field.
- imem_ready  in  1  instruction memory returns valid word this cycle.
- dmem_ready  in  1  data memory completes access this cycle.
- branch_taken  in  1  ALU compare result; sampled in EXEC for branches.
- imem_req  out  1  instruction fetch request.
- ir_load  out  1  load instruction register.
- pc_write  out  1  update PC; exactly one pulse per retired instruction.
- pc_src  out  1  0 = PC+4, 1 = branch/JAL target.
- alu_op  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- reg_write  out  1  register-file write enable.
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4.
- trap  out  1  sticky trap indication.
- trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = dmem timeout.
- instret  out  32  retired-instruction count.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Supported opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, LUI=0110111.
- FETCH: imem_req=1. On imem_ready, ir_load=1 in the same cycle and go to DECODE; otherwise stay.
- DECODE: classify the opcode. Illegal encodings go to TRAP with cause 1; all others go to EXEC.
- Illegal encodings:
  - unknown opcode;
  - R-type with func7 ∉ {0000000, 0100000};
  - R-type with func7=0100000 and func3 ∉ {000, 101};
  - I-ALU shift (func3 001/101) with a bad func7 under the same rule;
  - LOAD func3 ∉ {000, 001, 010, 100, 101};
  - STORE func3 > 010;
  - BRANCH func3 ∈ {010, 011}.
- EXEC, alu_op selection:
  - R-type: func3 map, with func7[5] selecting SUB/SRA.
  - I-ALU: same map, except func3=000 is always ADD.
  - LOAD/STORE: ADD.
  - BRANCH: SUB.
  - LUI: PASS_B.
  - JAL: ADD.
- EXEC, alu_src_b=1 for all except R-type and BRANCH.
- EXEC, next state:
  - BRANCH: pc_write=1 with pc_src=branch_taken, then FETCH.
  - LOAD/STORE: MEM.
  - All others: WB.
- MEM: dmem_req=1; dmem_we=1 for STORE.
  - On dmem_ready, LOAD goes to WB.
  - On dmem_ready, STORE asserts pc_write (pc_src=0) and goes to FETCH.
  - Wait counter increments each MEM cycle without ready. When it reaches MEM_TIMEOUT, go to TRAP with cause 2. The counter clears on leaving MEM.
- WB: reg_write=1 unless rd=0. wb_sel = 1 for LOAD, 2 for JAL, else 0. pc_write=1 with pc_src=1 for JAL, else 0. Then FETCH.
- TRAP: trap=1; all request and enable outputs are 0. Exit only via reset.
- instret: +1 on every pc_write, wraps modulo 2^32.
- alu_op, alu_src_b, and wb_sel are held at their EXEC values through MEM and WB.

## Timing
- Reset (async assert, sync-safe deassert): state=FETCH, all outputs 0, trap_cause=0, instret=0, wait counter=0. Reset mid-instruction aborts it with no pc_write.
- All control outputs are Moore-style from state, plus combinational qualification by imem_ready, dmem_ready, branch_taken and decoded fields within the same cycle.
- Zero-wait latency:
  - BRANCH: 3 cycles.
  - R, I-ALU, LUI, JAL, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle adds one.
- Decoder fields must be stable from the cycle after ir_load until pc_write.
- Timeout boundary: with MEM_TIMEOUT=N, dmem_ready arriving in MEM cycle N still completes. Absence of ready through N cycles enters TRAP on the next edge.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - alu_op encodings;
  - state enum;
  - wb_sel and trap_cause encodings.
- Sub-module alu_op_decoder: combinational (opcode, func3, func7) → (alu_op, alu_src_b, illegal), instantiated once.

## Test plan
- R-type ADD then SUB (func7=0100000), ready always high → alu_op 0 then 1, reg_write in cycle 4 of each, instret=2 after 8 cycles.
- LOAD with dmem_ready delayed 3 cycles → MEM lasts 4 cycles, wb_sel=1, total 8 cycles, single pc_write.
- BRANCH with branch_taken=1, then BRANCH with taken=0 → pc_src=1 then 0, pc_write in cycle 3 of each, reg_write never asserted.
- JAL with rd=0 → wb_sel=2, reg_write=0, pc_src=1. Then I-ALU with rd=5 → reg_write=1.
- Opcode 1111111, and R-type func7=0100000 with func3=001 → trap=1, trap_cause=1, instret unchanged, outputs idle until rst_n low.
- STORE with MEM_TIMEOUT=4 and dmem_ready never high → TRAP cause 2 after 4 MEM cycles. Then rst_n pulsed low mid-FETCH → all outputs 0, instret=0, FETCH resumes.
